wave_capture: RTL and testbench
===============================

// Module: wave_capture
// PURPOSE
//  Producer side of the double-buffered sample RAM that wave_display reads.
//  - Watches the audio sample stream and arms on a positive-going zero crossing.
//  - Writes NUM_SAMPLES display-scaled samples into the half of the RAM the display is not reading.
//  - Flips read_index once wave_display reports idle (vertical blank).
//  - Sits between the codec/note-player sample stream and the sample RAM that feeds wave_display.
// PARAMETERS
//  SAMPLE_W    16    width of signed input sample
//  ADDR_W      8     log2(NUM_SAMPLES); RAM address is ADDR_W+1 bits (MSB = buffer select)
//  TIMEOUT     4096  strobes in ARMED before a forced trigger (only with WAVE_TRIG_TIMEOUT_EN)
// PORTS
//  clk                input   1         system clock
//  reset              input   1         asynchronous, active-low reset
//  new_sample_ready   input   1         one-cycle strobe: new_sample_in valid
//  new_sample_in      input   SAMPLE_W  signed two's-complement audio sample
//  wave_display_idle  input   1         high while wave_display is not reading RAM
//  write_address      output  ADDR_W+1  {~read_index, sample count}
//  write_enable       output  1         one-cycle RAM write strobe
//  write_sample       output  8         offset-binary display sample
//  read_index         output  1         buffer half wave_display reads
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, low) forces: state=ARMED, count=0, prev_neg=0, read_index=0, write_enable=0,
//    write_address=0, write_sample=0. Reset mid-capture abandons the partial buffer; no flip occurs.
//  - prev_neg <= new_sample_in[SAMPLE_W-1] on every strobe, in every state.
//  - Positive crossing = strobe AND prev_neg==1 AND new_sample_in[MSB]==0.
//  - Scaling: write_sample = {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: 7]}.
//    Examples: 16'h8000->8'h00, 16'h0000->8'h80, 16'h7FFF->8'hFF.
//  - State ARMED: ignore samples until a positive crossing is seen.
//    - Crossing sample is the first one written, at count 0.
//    - Next state: ACTIVE, count=1.
//  - State ACTIVE: each strobe writes the current sample and increments count.
//    - Write occurs at address {~read_index, count}.
//    - write_enable pulses the cycle after the strobe: one-cycle latency, one pulse per strobe.
//    - Count wraps at 2^ADDR_W. The write at count==2^ADDR_W-1 is the last one.
//    - Next state after the last write: WAIT, count=0.
//  - State WAIT: strobes are not written; prev_neg still tracks.
//    - On the first cycle with wave_display_idle==1: read_index toggles, next state ARMED.
//    - A crossing in the same cycle as the flip is not captured.
//  - Back-to-back strobes on consecutive cycles are supported with no dropped samples.
//  - write_address/write_sample hold their last values when write_enable==0.
// CONFIGURATION
//  - WAVE_TRIG_TIMEOUT_EN defined:
//    - ARMED counts strobes.
//    - When TIMEOUT strobes pass with no crossing, the current sample is force-triggered as count 0.
//    - The timeout counter clears on entry to ARMED.
//    - Flat or DC input still refreshes the display.
//  - WAVE_TRIG_TIMEOUT_EN undefined: no timeout counter. ARMED waits indefinitely.
// STRUCTURE
//  - Shared package wave_pkg:
//    - state encoding localparams ST_ARMED=2'd0, ST_ACTIVE=2'd1, ST_WAIT=2'd2
//    - DISP_W=8
//    - to_display() scaling function, also used by the display-side model in the bench
//  - Single module; optional sub-module zero_cross_detect: prev_neg register + crossing pulse.
//  - Unused state 2'd3 recovers to ARMED.
// TESTING
//  1. Reset low mid-ACTIVE (count=37) -> next cycle: state ARMED, write_enable=0, read_index=0.
//     No further writes until a new crossing.
//  2. Samples -5, +3, then 255 ramp strobes, display_idle=0.
//     Writes 256 pulses, addr 9'h100..9'h1FF; first data is to_display(+3)=8'h80.
//  3. After test 2, hold idle=0 for 100 cycles with strobes -> no writes, read_index stays 0.
//     Raise idle -> read_index=1 next cycle; the next capture writes 9'h000..9'h0FF.
//  4. Samples 16'h8000/16'h7FFF/16'h0000 in ACTIVE -> write_sample 8'h00/8'hFF/8'h80.
//  5. Strobe every cycle for 256 cycles -> exactly 256 write_enable pulses, contiguous addresses.
//  6. WAVE_TRIG_TIMEOUT_EN, TIMEOUT=16, constant +100 input -> trigger on the 16th strobe.
//     Without the macro -> no writes after 1000 strobes.

Source files
------------

// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
//   Shared definitions for the waveform capture path (wave_capture) and the
//   display-side consumer of the sample RAM.
//
//   Contents:
//     state_t     capture FSM encoding (ST_ARMED / ST_ACTIVE / ST_WAIT);
//                 the fourth code 2'd3 is unused and recovers to ST_ARMED
//     DISP_W      width of one display sample stored in the RAM
//     to_display  signed audio sample -> offset-binary display sample
// ---------------------------------------------------------------------------
package wave_pkg;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam int DISP_W = 8;

  // Takes the top DISP_W bits of a signed two's-complement sample and
  // returns offset binary: flipping the sign bit maps the most negative
  // value to 0, zero to mid-scale and the most positive value to full scale.
  function automatic logic [DISP_W-1:0] to_display(input logic [DISP_W-1:0] top_bits);
    return {~top_bits[DISP_W-1], top_bits[DISP_W-2:0]};
  endfunction

endpackage

// File: rtl/wave_capture_if.sv
// ---------------------------------------------------------------------------
// wave_capture_if
//   Bundles the sample stream, the display status and the RAM write port
//   around wave_capture.
//
//   Signals:
//     new_sample_ready   one-cycle strobe, new_sample_in valid
//     new_sample_in      signed audio sample, SAMPLE_W bits
//     wave_display_idle  high while wave_display is not reading the RAM
//     write_address      {~read_index, sample count}, ADDR_W+1 bits
//     write_enable       one-cycle RAM write strobe
//     write_sample       offset-binary display sample, DISP_W bits
//     read_index         RAM half that wave_display reads
//
//   Handshake: neither side has a ready/backpressure signal. new_sample_ready
//   is a valid-only strobe; the sample is consumed in the cycle it is high.
//   write_enable is likewise valid-only: the RAM must accept every write in
//   the cycle it is asserted. write_address/write_sample hold their last
//   values while write_enable is low.
//
//   Modports:
//     master  wave_capture side (consumes samples, drives the RAM write port)
//     slave   environment side (sample source, RAM, display)
// ---------------------------------------------------------------------------
interface wave_capture_if #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 8
);
  import wave_pkg::*;

  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [ADDR_W:0]     write_address;
  logic                write_enable;
  logic [DISP_W-1:0]   write_sample;
  logic                read_index;

  modport master (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index
  );

  modport slave (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index
  );

endinterface

// File: rtl/wave_capture_zero_cross_detect.sv
// ---------------------------------------------------------------------------
// zero_cross_detect
//   Remembers the sign of the previous strobed sample and flags a
//   positive-going zero crossing (previous sample negative, current sample
//   non-negative) in the cycle of the strobe.
//
//   Ports:
//     clk       system clock
//     reset     asynchronous, active-low reset
//     strobe    sample valid strobe
//     sign      sign bit of the current sample
//     prev_neg  registered sign of the last strobed sample
//     crossing  combinational crossing pulse, qualified by strobe
// ---------------------------------------------------------------------------
module zero_cross_detect (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic sign,
  output logic prev_neg,
  output logic crossing
);

  // Tracks on every strobe regardless of what the capture FSM is doing, so
  // the first sample after a buffer flip already has a valid predecessor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_neg <= 1'b0;
    end else if (strobe) begin
      prev_neg <= sign;
    end
  end

  assign crossing = strobe & prev_neg & ~sign;

endmodule

// File: rtl/wave_capture.sv
// ---------------------------------------------------------------------------
// wave_capture
//   Producer side of the double-buffered sample RAM read by wave_display.
//   Arms on a positive-going zero crossing, writes 2**ADDR_W display-scaled
//   samples into the RAM half the display is not reading, then waits for the
//   display to go idle (vertical blank) and flips read_index.
//
//   Parameters:
//     SAMPLE_W  width of the signed input sample (>= DISP_W)
//     ADDR_W    log2 of samples per buffer; RAM address is ADDR_W+1 bits
//     TIMEOUT   strobes in ST_ARMED before a forced trigger
//
//   Build option:
//     WAVE_TRIG_TIMEOUT_EN  when defined, ST_ARMED counts strobes and forces
//                           a trigger on the TIMEOUT-th strobe without a
//                           crossing, so flat or DC input still refreshes the
//                           display. When undefined ST_ARMED waits
//                           indefinitely and no counter is built.
//
//   Ports:
//     clk        system clock
//     reset      asynchronous, active-low reset
//     bus        wave_capture_if.master (sample stream, idle, RAM write port)
//     dbg_state  current capture FSM state
//
//   All bus outputs are registered; a write appears one cycle after the
//   strobe that carried its sample.
// ---------------------------------------------------------------------------
module wave_capture
  import wave_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  wave_capture_if.master   bus,
  output state_t           dbg_state
);

  // -------------------------------------------------------------------------
  // Input decode
  // -------------------------------------------------------------------------
  logic              strobe;
  logic              sample_neg;
  logic              prev_neg;
  logic              crossing;
  logic [DISP_W-1:0] scaled;

  assign strobe     = bus.new_sample_ready;
  assign sample_neg = bus.new_sample_in[SAMPLE_W-1];
  assign scaled     = to_display(bus.new_sample_in[SAMPLE_W-1 -: DISP_W]);

  // Bits below the display resolution are deliberately discarded.
  generate
    if (SAMPLE_W > DISP_W) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^bus.new_sample_in[SAMPLE_W-DISP_W-1:0];
    end
  endgenerate

  zero_cross_detect u_zero_cross (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe),
    .sign     (sample_neg),
    .prev_neg (prev_neg),
    .crossing (crossing)
  );

  // -------------------------------------------------------------------------
  // Optional trigger timeout
  // -------------------------------------------------------------------------
  logic timeout_hit;

`ifdef WAVE_TRIG_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_next;

  // The counter holds the number of strobes already seen in ST_ARMED, so
  // the TIMEOUT-th strobe sees TIMEOUT-1 and becomes the forced trigger.
  assign timeout_hit = strobe && (to_cnt_q == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Capture FSM and output registers
  // -------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_next;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_next;
  logic              read_index_q;
  logic              read_index_next;
  logic              write_enable_q;
  logic              write_enable_next;
  logic [ADDR_W:0]   write_address_q;
  logic [ADDR_W:0]   write_address_next;
  logic [DISP_W-1:0] write_sample_q;
  logic [DISP_W-1:0] write_sample_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_ARMED;
      count_q         <= '0;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_sample_q  <= '0;
    end else begin
      state_q         <= state_next;
      count_q         <= count_next;
      read_index_q    <= read_index_next;
      write_enable_q  <= write_enable_next;
      write_address_q <= write_address_next;
      write_sample_q  <= write_sample_next;
    end
  end

`ifdef WAVE_TRIG_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_next;
    end
  end
`endif

  always_comb begin
    state_next         = state_q;
    count_next         = count_q;
    read_index_next    = read_index_q;
    write_enable_next  = 1'b0;
    write_address_next = write_address_q;
    write_sample_next  = write_sample_q;
`ifdef WAVE_TRIG_TIMEOUT_EN
    to_cnt_next        = to_cnt_q;
`endif

    case (state_q)
      ST_ARMED: begin
        // The triggering sample itself is the first one stored (count 0).
        if (crossing || timeout_hit) begin
          write_enable_next  = 1'b1;
          write_address_next = {~read_index_q, {ADDR_W{1'b0}}};
          write_sample_next  = scaled;
          count_next         = ADDR_W'(1);
          state_next         = ST_ACTIVE;
`ifdef WAVE_TRIG_TIMEOUT_EN
          to_cnt_next        = '0;
`endif
        end else if (strobe) begin
`ifdef WAVE_TRIG_TIMEOUT_EN
          to_cnt_next = to_cnt_q + TO_W'(1);
`endif
        end
      end

      ST_ACTIVE: begin
        if (strobe) begin
          write_enable_next  = 1'b1;
          write_address_next = {~read_index_q, count_q};
          write_sample_next  = scaled;
          // Natural wrap returns count to 0 for the next buffer.
          count_next         = count_q + ADDR_W'(1);
          if (count_q == {ADDR_W{1'b1}}) begin
            state_next = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // Flip only while the display is not reading. A crossing in this
        // same cycle is intentionally dropped: the new write half is only
        // valid from the next cycle on.
        if (bus.wave_display_idle) begin
          read_index_next = ~read_index_q;
          state_next      = ST_ARMED;
`ifdef WAVE_TRIG_TIMEOUT_EN
          to_cnt_next     = '0;
`endif
        end
      end

      default: begin
        state_next = ST_ARMED;
        count_next = '0;
`ifdef WAVE_TRIG_TIMEOUT_EN
        to_cnt_next = '0;
`endif
      end
    endcase
  end

  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_sample  = write_sample_q;
  assign bus.read_index    = read_index_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_wave_capture.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_wave_capture
//   Directed bench for wave_capture: reset, mid-capture reset, a full
//   back-to-back capture into the upper half, WAIT behaviour and buffer flip,
//   a spaced capture into the lower half, and the trigger timeout option.
// ---------------------------------------------------------------------------
module tb_wave_capture;
  import wave_pkg::*;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 8;
  localparam int TIMEOUT  = 16;
  localparam int W        = ADDR_W + 1 + DISP_W;

  // ---------------------------------------------------------------- clock/reset
  logic   clk = 1'b0;
  logic   reset = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  wave_capture_if #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus ();

  wave_capture #(
    .SAMPLE_W (SAMPLE_W),
    .ADDR_W   (ADDR_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int            checks   = 0;
  int            errors   = 0;
  int            wr_count = 0;
  logic [W-1:0]  exp_q[$];
  logic [DISP_W-1:0] last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [ADDR_W:0] addr, input logic [DISP_W-1:0] data);
    exp_q.push_back({addr, data});
  endtask

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      wr_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0h expected=none",
               {bus.write_address, bus.write_sample});
      end
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", 32'({bus.write_address, bus.write_sample}), 32'(e));
      end
    end
  end

  // Writes land one cycle after their strobe; a few cycles is a hard bound.
  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic strobe(input logic [SAMPLE_W-1:0] s);
    @(negedge clk);
    bus.new_sample_in    = s;
    bus.new_sample_ready = 1'b1;
    @(negedge clk);
    bus.new_sample_ready = 1'b0;
  endtask

  function automatic logic [DISP_W-1:0] disp(input logic [SAMPLE_W-1:0] s);
    return to_display(s[SAMPLE_W-1 -: DISP_W]);
  endfunction

  // ---------------------------------------------------------------- sequence
  initial begin
    int wr0;
    logic [SAMPLE_W-1:0] v;
    logic [DISP_W-1:0]   d;

    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dbg_state), 32'(ST_ARMED));
    check("reset_we", 32'(bus.write_enable), 32'd0);
    check("reset_addr", 32'(bus.write_address), 32'd0);
    check("reset_sample", 32'(bus.write_sample), 32'd0);
    check("reset_read_index", 32'(bus.read_index), 32'd0);
    reset = 1'b1;

    // Test 1: reset mid-ACTIVE at count 37
    strobe(16'hFFFB);
    push(9'h100, 8'h80);
    strobe(16'h0003);
    for (int k = 1; k <= 36; k++) begin
      v = 16'(1000 + k * 300);
      push(9'(9'h100 + k), disp(v));
      strobe(v);
    end
    drain("t1_drain");
    check("t1_active", 32'(dbg_state), 32'(ST_ACTIVE));
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("t1_state_after_reset", 32'(dbg_state), 32'(ST_ARMED));
    check("t1_we_after_reset", 32'(bus.write_enable), 32'd0);
    check("t1_ri_after_reset", 32'(bus.read_index), 32'd0);
    check("t1_addr_after_reset", 32'(bus.write_address), 32'd0);
    reset = 1'b1;
    wr0 = wr_count;
    for (int k = 0; k < 10; k++) strobe(16'd500);
    repeat (3) @(negedge clk);
    check("t1_no_writes_without_crossing", 32'(wr_count - wr0), 32'd0);

    // Tests 2/4/5: back-to-back capture into the upper half
    wr0 = wr_count;
    for (int j = 0; j <= 256; j++) begin
      @(negedge clk);
      if (j == 0) begin
        v = 16'hFFFB;
      end else if (j == 1) begin
        v = 16'h0003;
        push(9'h100, 8'h80);
      end else begin
        case (j - 1)
          1:       begin v = 16'h8000; d = 8'h00; end
          2:       begin v = 16'h7FFF; d = 8'hFF; end
          3:       begin v = 16'h0000; d = 8'h80; end
          default: begin v = 16'((j - 1) * 251 - 30000); d = disp(v); end
        endcase
        push(9'(9'h100 + (j - 1)), d);
        last_data = d;
      end
      bus.new_sample_in    = v;
      bus.new_sample_ready = 1'b1;
    end
    @(negedge clk);
    bus.new_sample_ready = 1'b0;
    drain("t2_drain");
    check("t2_write_count", 32'(wr_count - wr0), 32'd256);
    check("t2_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("t2_ri", 32'(bus.read_index), 32'd0);

    // Test 3: WAIT ignores strobes until idle, then flips
    wr0 = wr_count;
    for (int i = 0; i < 50; i++) strobe((i % 2 == 0) ? 16'd100 : 16'hFF9C);
    check("t3_no_writes_in_wait", 32'(wr_count - wr0), 32'd0);
    check("t3_ri_held", 32'(bus.read_index), 32'd0);
    check("t3_still_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("t3_addr_hold", 32'(bus.write_address), 32'h1FF);
    check("t3_sample_hold", 32'(bus.write_sample), 32'(last_data));
    @(negedge clk);
    bus.wave_display_idle = 1'b1;
    bus.new_sample_in     = 16'd50;
    bus.new_sample_ready  = 1'b1;
    @(negedge clk);
    bus.wave_display_idle = 1'b0;
    bus.new_sample_ready  = 1'b0;
    check("t3_ri_flipped", 32'(bus.read_index), 32'd1);
    check("t3_armed_after_flip", 32'(dbg_state), 32'(ST_ARMED));
    repeat (3) @(negedge clk);
    check("t3_flip_cycle_crossing_dropped", 32'(wr_count - wr0), 32'd0);

    strobe(16'hFFF9);
    push(9'h000, 8'h80);
    strobe(16'h0009);
    for (int k = 1; k <= 255; k++) begin
      v = 16'(k * 97 + 2);
      push(9'(k), disp(v));
      strobe(v);
    end
    drain("t3_drain");
    check("t3_write_count", 32'(wr_count - wr0), 32'd256);
    check("t3_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("t3_ri_during_capture", 32'(bus.read_index), 32'd1);

    // Flip back, then constant DC input
    @(negedge clk);
    bus.wave_display_idle = 1'b1;
    @(negedge clk);
    bus.wave_display_idle = 1'b0;
    check("t6_ri_flipped", 32'(bus.read_index), 32'd0);
    wr0 = wr_count;
`ifdef WAVE_TRIG_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT - 1; k++) strobe(16'd100);
    repeat (3) @(negedge clk);
    check("t6_no_early_trigger", 32'(wr_count - wr0), 32'd0);
    push(9'h100, 8'h80);
    strobe(16'd100);
    drain("t6_drain");
    check("t6_forced_trigger", 32'(wr_count - wr0), 32'd1);
    check("t6_active_after_trigger", 32'(dbg_state), 32'(ST_ACTIVE));
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      bus.new_sample_in    = 16'd100;
      bus.new_sample_ready = 1'b1;
    end
    @(negedge clk);
    bus.new_sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_trigger_on_dc", 32'(wr_count - wr0), 32'd0);
    check("t6_still_armed", 32'(dbg_state), 32'(ST_ARMED));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
